// File: rtl/ecc_pkg.sv
// ecc_pkg: definitions shared by the serial ECC modular add/subtract front end.
//   state_t       : controller states of the serial front end
//   OP_ADD/OP_SUB : encodings of the op input
//   P_SECP256K1   : secp256k1 field prime p = 2^256 - 2^32 - 977
//   N_SECP256K1   : secp256k1 group order n
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC1 = 3'd2,
        CALC2 = 3'd3,
        SHOUT = 3'd4
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [255:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] N_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

endpackage

// File: rtl/mod_addsub_core.sv
// mod_addsub_core: two-stage registered modular add/subtract plus result shifter.
//   clk, rst : clock, asynchronous active-high reset
//   calc     : stage 1 enable, raw = a +/- b (WIDTH+1 bits, top bit = carry/borrow)
//   corr     : stage 2 enable, one modular correction step into the result register
//   shift    : shift the result register right by one (zero fill)
//   clear    : zero the result register (wins over corr/shift)
//   op       : OP_ADD / OP_SUB
//   a, b, m  : operands and modulus (held stable by the caller)
//   lsb      : bit 0 of the result register
module mod_addsub_core
    import ecc_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             calc,
    input  logic             corr,
    input  logic             shift,
    input  logic             clear,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             lsb
);

    logic [WIDTH:0]   raw_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] corr_next;

    // Exactly one correction step: results are exact only for reduced inputs.
    always_comb begin
        corr_next = raw_reg[WIDTH-1:0];
        if (op == OP_SUB) begin
            if (raw_reg[WIDTH])
                corr_next = raw_reg[WIDTH-1:0] + m;
        end else begin
            if (raw_reg >= {1'b0, m})
                corr_next = WIDTH'(raw_reg - {1'b0, m});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_reg <= '0;
            res_reg <= '0;
        end else begin
            if (calc) begin
                if (op == OP_SUB)
                    raw_reg <= {1'b0, a} - {1'b0, b};
                else
                    raw_reg <= {1'b0, a} + {1'b0, b};
            end
            // The result register drives the serial output directly, so it is
            // cleared on abort and drains to zero as it shifts out; this keeps
            // the output low whenever no result bit is being presented.
            if (clear)
                res_reg <= '0;
            else if (corr)
                res_reg <= corr_next;
            else if (shift)
                res_reg <= {1'b0, res_reg[WIDTH-1:1]};
        end
    end

    assign lsb = res_reg[0];

endmodule

// File: rtl/serial_mod_addsub.sv
// serial_mod_addsub: bit-serial front end for modular add/subtract.
// Shifts two WIDTH-bit operands in LSB-first, computes (a+b) mod M or
// (a-b) mod M with M picked from four parameter moduli, and shifts the
// result out LSB-first.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : launch pulse, honoured only in IDLE (op/sel sampled with it)
//   op           : 0 = add, 1 = subtract
//   sel          : modulus select (MOD0..MOD3)
//   abort        : synchronous abort back to IDLE, beats start
//   sdi_a, sdi_b : serial operands, LSB first, bit k on cycle k+1
//   busy         : high in every state but IDLE
//   sdo, sdo_vld : serial result, bit k on cycle WIDTH+3+k; sdo is 0 when not valid
//   done         : one-cycle pulse on the final result bit
module serial_mod_addsub
    import ecc_pkg::*;
#(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] MOD0  = WIDTH'(P_SECP256K1),
    parameter logic [WIDTH-1:0] MOD1  = WIDTH'(N_SECP256K1),
    parameter logic [WIDTH-1:0] MOD2  = MOD0,
    parameter logic [WIDTH-1:0] MOD3  = MOD1,
    parameter int               CW    = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [1:0] sel,
    input  logic       abort,
    input  logic       sdi_a,
    input  logic       sdi_b,
    output logic       busy,
    output logic       sdo,
    output logic       sdo_vld,
    output logic       done
);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             op_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] m_sel;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sdo_vld_reg;
    logic             done_reg;
    logic             cnt_last;
    logic             accept;

    assign cnt_last = (cnt_reg == CW'(WIDTH - 1));
    assign accept   = (state_reg == IDLE) && start && !abort;

    always_comb begin
        m_sel = MOD0;
        case (sel)
            2'd0:    m_sel = MOD0;
            2'd1:    m_sel = MOD1;
            2'd2:    m_sel = MOD2;
            default: m_sel = MOD3;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (cnt_last) state_next = CALC1;
            CALC1:   state_next = CALC2;
            CALC2:   state_next = SHOUT;
            SHOUT:   if (cnt_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= 1'b0;
            m_reg       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sdo_vld_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sdo_vld_reg <= (state_next == SHOUT);
            // Registered one cycle early so it lines up with the last sdo bit.
            done_reg    <= (state_reg == SHOUT) && (cnt_reg == CW'(WIDTH - 2)) && !abort;

            if (accept) begin
                cnt_reg <= '0;
                op_reg  <= op;
                m_reg   <= m_sel;
            end else if (state_reg == LOAD || state_reg == SHOUT) begin
                cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
            end

            // After WIDTH shifts bit 0 of each operand sits at index 0.
            if (state_reg == LOAD) begin
                a_reg <= {sdi_a, a_reg[WIDTH-1:1]};
                b_reg <= {sdi_b, b_reg[WIDTH-1:1]};
            end
        end
    end

    mod_addsub_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .calc ((state_reg == CALC1) && !abort),
        .corr ((state_reg == CALC2) && !abort),
        .shift(state_reg == SHOUT),
        .clear(abort),
        .op   (op_reg),
        .a    (a_reg),
        .b    (b_reg),
        .m    (m_reg),
        .lsb  (sdo)
    );

    assign busy    = (state_reg != IDLE);
    assign sdo_vld = sdo_vld_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_serial_mod_addsub.sv
module tb_serial_mod_addsub;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, op, abort, sdi_a, sdi_b;
    logic [1:0] sel;
    logic       busy, sdo, sdo_vld, done;

    int n_cmp = 0;
    int n_bad = 0;
    int mods[4] = '{251, 239, 251, 239};

    serial_mod_addsub #(
        .WIDTH(W),
        .MOD0 (8'd251),
        .MOD1 (8'd239)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .sel    (sel),
        .abort  (abort),
        .sdi_a  (sdi_a),
        .sdi_b  (sdi_b),
        .busy   (busy),
        .sdo    (sdo),
        .sdo_vld(sdo_vld),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: one modular correction step from the plain arithmetic sum/difference.
    function automatic int model(input int a, input int b, input int opv, input int m);
        int r;
        if (opv == 0) begin
            r = a + b;
            if (r >= m) r = r - m;
        end else begin
            r = a - b;
            if (r < 0) r = r + 256 + m;
        end
        return r % 256;
    endfunction

    // Runs one operation starting on the current cycle (cycle 0).
    // abort_cyc / rst_cyc < 0 disable those events; extra pulses start on cycles 4 and 12.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic opv,
                          input logic [1:0] selv, input int abort_cyc, input bit extra,
                          input int rst_cyc, input string tag);
        logic [7:0] got;
        int         exp;
        bit         e_busy, e_vld, e_done;
        got = '0;
        exp = model(int'(a), int'(b), int'(opv), mods[selv]);
        for (int c = 0; c <= 18; c++) begin
            start = (c == 0) || (extra && (c == 4 || c == 12));
            op    = (c == 0) ? opv : ~opv;
            sel   = (c == 0) ? selv : ~selv;
            abort = (c == abort_cyc);
            sdi_a = (c >= 1 && c <= W) ? a[c-1] : 1'($urandom);
            sdi_b = (c >= 1 && c <= W) ? b[c-1] : 1'($urandom);
            if (c == rst_cyc) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, " rst busy"}, 32'(busy), 0);
                chk({tag, " rst sdo_vld"}, 32'(sdo_vld), 0);
                chk({tag, " rst done"}, 32'(done), 0);
                chk({tag, " rst sdo"}, 32'(sdo), 0);
                start = 1'b0;
                abort = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                $display("%s: a=%0d b=%0d op=%0d sel=%0d reset at cycle %0d", tag, a, b, opv, selv, c);
                return;
            end
            @(negedge clk);
            e_busy = (c >= 1) && (abort_cyc < 0 || c <= abort_cyc);
            e_vld  = (c >= 11) && (abort_cyc < 0 || c <= abort_cyc);
            e_done = (c == 18) && (abort_cyc < 0);
            chk({tag, " busy"}, 32'(busy), 32'(e_busy));
            chk({tag, " sdo_vld"}, 32'(sdo_vld), 32'(e_vld));
            chk({tag, " done"}, 32'(done), 32'(e_done));
            if (e_vld) got[c-11] = sdo;
            else chk({tag, " sdo idle"}, 32'(sdo), 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_cyc < 0) begin
            chk({tag, " result"}, 32'(got), 32'(exp));
            $display("%s: a=%0d b=%0d op=%0d sel=%0d result=%0d expected=%0d", tag, a, b, opv, selv, got, exp);
        end else begin
            $display("%s: a=%0d b=%0d op=%0d sel=%0d aborted at cycle %0d", tag, a, b, opv, selv, abort_cyc);
        end
    endtask

    initial begin
        int m;
        logic [7:0] ra, rb;
        logic       rop;
        logic [1:0] rsel;
        rst = 1'b1; start = 1'b0; op = 1'b0; sel = 2'd0; abort = 1'b0; sdi_a = 1'b0; sdi_b = 1'b0;
        #12;
        chk("reset busy", 32'(busy), 0);
        chk("reset sdo_vld", 32'(sdo_vld), 0);
        chk("reset done", 32'(done), 0);
        chk("reset sdo", 32'(sdo), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle busy", 32'(busy), 0);

        run_op(8'd200, 8'd100, 1'b0, 2'd0, -1, 1'b0, -1, "add sel0");
        chk("model add sel0", 32'(model(200, 100, 0, 251)), 49);
        run_op(8'd5, 8'd10, 1'b1, 2'd0, -1, 1'b0, -1, "sub sel0");
        run_op(8'd5, 8'd10, 1'b1, 2'd1, -1, 1'b0, -1, "sub sel1");
        run_op(8'd238, 8'd1, 1'b0, 2'd1, -1, 1'b0, -1, "add wrap");
        run_op(8'd0, 8'd0, 1'b0, 2'd1, -1, 1'b0, -1, "add zero");
        run_op(8'd120, 8'd118, 1'b0, 2'd1, -1, 1'b0, -1, "add max");
        run_op(8'd77, 8'd33, 1'b0, 2'd0, 5, 1'b0, -1, "abort");
        run_op(8'd1, 8'd2, 1'b0, 2'd0, -1, 1'b0, -1, "after abort");
        run_op(8'd200, 8'd100, 1'b0, 2'd0, -1, 1'b1, -1, "restart ignored");
        run_op(8'd3, 8'd200, 1'b1, 2'd1, -1, 1'b1, -1, "restart sub");
        run_op(8'd150, 8'd140, 1'b0, 2'd2, -1, 1'b0, 13, "async rst");
        run_op(8'd150, 8'd140, 1'b0, 2'd2, -1, 1'b0, -1, "after rst");

        // abort together with start while idle: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start+abort idle", 32'(busy), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            rop  = 1'($urandom);
            rsel = 2'($urandom);
            m    = mods[rsel];
            ra   = 8'($urandom_range(0, m - 1));
            rb   = 8'($urandom_range(0, m - 1));
            run_op(ra, rb, rop, rsel, -1, 1'b0, -1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
